pulp_level_shifter_out_seq: RTL and testbench

Output-side level-shifter and isolation sequencer for a switchable power domain. It is the counterpart of the input level shifter: it drives signals out of a switchable domain into the always-on domain. It registers the outgoing bus and clamps it to a fixed value while the source domain is isolated. It also runs the isolate / power-off / power-on / de-isolate sequence with a request/acknowledge handshake toward the power manager.

---
 rtl/pulp_level_shifter_out_seq.sv | 122 ++++++++++++
 tb/tb_pulp_level_shifter_out_seq.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/pulp_level_shifter_out_seq.sv
// rtl/pulp_level_shifter_out_seq.sv - output level shifter with clamp and isolate/power sequencer
module pulp_level_shifter_out_seq #(
   parameter int unsigned      WIDTH            = 32,
   parameter logic [WIDTH-1:0] CLAMP_VALUE      = '0,
   parameter int unsigned      ISO_SETUP_CYCLES = 4,
   parameter int unsigned      ISO_HOLD_CYCLES  = 4,
   parameter int unsigned      PWR_TIMEOUT      = 256
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic [WIDTH-1:0] data_i,
   output logic [WIDTH-1:0] data_o,
   input  logic             pwr_down_req_i,
   output logic             pwr_down_ack_o,
   input  logic             pwr_up_req_i,
   output logic             pwr_up_ack_o,
   input  logic             pwr_good_i,
   output logic             pwr_en_o,
   output logic             iso_o,
   output logic             busy_o,
   output logic             err_o
);

   localparam int unsigned ISO_MAX = (ISO_SETUP_CYCLES > ISO_HOLD_CYCLES) ? ISO_SETUP_CYCLES : ISO_HOLD_CYCLES;
   localparam int unsigned CNT_MAX = (ISO_MAX > PWR_TIMEOUT) ? ISO_MAX : PWR_TIMEOUT;
   localparam int unsigned CW      = (CNT_MAX < 1) ? 1 : $clog2(CNT_MAX + 1);

   localparam logic [CW-1:0] SETUP_LAST   = CW'(ISO_SETUP_CYCLES - 1);
   localparam logic [CW-1:0] HOLD_LAST    = CW'(ISO_HOLD_CYCLES - 1);
   localparam logic [CW-1:0] TIMEOUT_LAST = CW'(PWR_TIMEOUT - 1);
   localparam logic [CW-1:0] CNT_ONE      = CW'(1);

   typedef enum logic [2:0] {
      ACTIVE, ISO_SETUP, PWR_OFF_WAIT, OFF, PWR_ON_WAIT, ISO_HOLD
   } state_t;

   state_t           state;
   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] data_q;
   logic             err_q;
   logic             down_ack_q;
   logic             up_ack_q;

   // cnt counts cycles already spent in the current state; it reloads on every transition
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state      <= PWR_ON_WAIT;
         cnt        <= '0;
         data_q     <= '0;
         err_q      <= 1'b0;
         down_ack_q <= 1'b0;
         up_ack_q   <= 1'b0;
      end else begin
         data_q     <= data_i;
         down_ack_q <= 1'b0;
         up_ack_q   <= 1'b0;
         case (state)
            ACTIVE: begin
               if (pwr_down_req_i) begin
                  state <= ISO_SETUP;
                  cnt   <= '0;
               end
            end
            ISO_SETUP: begin
               if (cnt == SETUP_LAST) begin
                  state <= PWR_OFF_WAIT;
                  cnt   <= '0;
               end else begin
                  cnt <= cnt + CNT_ONE;
               end
            end
            PWR_OFF_WAIT: begin
               if (!pwr_good_i || cnt == TIMEOUT_LAST) begin
                  if (pwr_good_i) err_q <= 1'b1;
                  state      <= OFF;
                  cnt        <= '0;
                  down_ack_q <= 1'b1;
               end else begin
                  cnt <= cnt + CNT_ONE;
               end
            end
            OFF: begin
               if (pwr_up_req_i) begin
                  state <= PWR_ON_WAIT;
                  cnt   <= '0;
               end
            end
            PWR_ON_WAIT: begin
               if (pwr_good_i || cnt == TIMEOUT_LAST) begin
                  if (!pwr_good_i) err_q <= 1'b1;
                  state <= ISO_HOLD;
                  cnt   <= '0;
               end else begin
                  cnt <= cnt + CNT_ONE;
               end
            end
            ISO_HOLD: begin
               if (cnt == HOLD_LAST) begin
                  state    <= ACTIVE;
                  cnt      <= '0;
                  up_ack_q <= 1'b1;
               end else begin
                  cnt <= cnt + CNT_ONE;
               end
            end
            default: begin
               state <= PWR_ON_WAIT;
               cnt   <= '0;
            end
         endcase
      end
   end

   assign iso_o          = (state != ACTIVE);
   assign pwr_en_o       = !(state == PWR_OFF_WAIT || state == OFF);
   assign busy_o         = !(state == ACTIVE || state == OFF);
   assign err_o          = err_q;
   assign pwr_down_ack_o = down_ack_q;
   assign pwr_up_ack_o   = up_ack_q;
   assign data_o         = iso_o ? CLAMP_VALUE : data_q;

endmodule

// File: tb/tb_pulp_level_shifter_out_seq.sv
// tb/tb_pulp_level_shifter_out_seq.sv - scoreboard bench for pulp_level_shifter_out_seq
module tb_pulp_level_shifter_out_seq;

   localparam int unsigned W     = 32;
   localparam logic [W-1:0] CLAMP = 32'hDEAD_BEEF;
   localparam int SETUP = 4;
   localparam int HOLD  = 4;
   localparam int TMO   = 16;

   logic         clk = 1'b0;
   logic         rst_i = 1'b0;
   logic [W-1:0] data_i = '0;
   logic [W-1:0] data_o;
   logic         pwr_down_req_i = 1'b0;
   logic         pwr_down_ack_o;
   logic         pwr_up_req_i = 1'b0;
   logic         pwr_up_ack_o;
   logic         pwr_good_i = 1'b0;
   logic         pwr_en_o;
   logic         iso_o;
   logic         busy_o;
   logic         err_o;

   pulp_level_shifter_out_seq #(
      .WIDTH(W), .CLAMP_VALUE(CLAMP), .ISO_SETUP_CYCLES(SETUP),
      .ISO_HOLD_CYCLES(HOLD), .PWR_TIMEOUT(TMO)
   ) dut (
      .clk_i(clk), .rst_i(rst_i), .data_i(data_i), .data_o(data_o),
      .pwr_down_req_i(pwr_down_req_i), .pwr_down_ack_o(pwr_down_ack_o),
      .pwr_up_req_i(pwr_up_req_i), .pwr_up_ack_o(pwr_up_ack_o),
      .pwr_good_i(pwr_good_i), .pwr_en_o(pwr_en_o), .iso_o(iso_o),
      .busy_o(busy_o), .err_o(err_o)
   );

   always #5 clk = ~clk;

   typedef enum {M_ACTIVE, M_SETUP, M_OFFW, M_OFF, M_ONW, M_HOLD} mphase_t;

   // reference: phase plus the cycle it was entered; durations come from elapsed time
   mphase_t      ph = M_ONW;
   int           ph_start = 0;
   int           cyc = 0;
   logic         m_err = 1'b0;
   logic         m_ackd = 1'b0;
   logic         m_acku = 1'b0;
   logic [W-1:0] m_dq = '0;

   logic [W+5:0] expq[$];
   int           checks = 0;
   int           errors = 0;

   logic         stuck = 1'b0;
   int           rail_dly = 2;
   int           rail_cnt = 2;

   function automatic logic [W+5:0] exp_vec();
      logic iso, pen, busy;
      iso  = (ph != M_ACTIVE);
      pen  = !(ph == M_OFFW || ph == M_OFF);
      busy = !(ph == M_ACTIVE || ph == M_OFF);
      return {iso ? CLAMP : m_dq, iso, pen, busy, m_err, m_ackd, m_acku};
   endfunction

   task automatic model_step();
      int age;
      mphase_t nxt;
      age = cyc - ph_start + 1;
      if (rst_i) begin
         ph = M_ONW; ph_start = cyc + 1;
         m_err = 1'b0; m_dq = '0; m_ackd = 1'b0; m_acku = 1'b0;
      end else begin
         nxt = ph;
         case (ph)
            M_ACTIVE: if (pwr_down_req_i) nxt = M_SETUP;
            M_SETUP:  if (age == SETUP) nxt = M_OFFW;
            M_OFFW: begin
               if (!pwr_good_i) nxt = M_OFF;
               else if (age == TMO) begin nxt = M_OFF; m_err = 1'b1; end
            end
            M_OFF:    if (pwr_up_req_i) nxt = M_ONW;
            M_ONW: begin
               if (pwr_good_i) nxt = M_HOLD;
               else if (age == TMO) begin nxt = M_HOLD; m_err = 1'b1; end
            end
            M_HOLD:   if (age == HOLD) nxt = M_ACTIVE;
            default:  nxt = M_ONW;
         endcase
         m_ackd = (nxt == M_OFF && ph != M_OFF);
         m_acku = (nxt == M_ACTIVE && ph != M_ACTIVE);
         if (nxt != ph) ph_start = cyc + 1;
         ph = nxt;
         m_dq = data_i;
      end
      cyc++;
      expq.push_back(exp_vec());
   endtask

   // rail follows the switch enable after rail_dly cycles unless stuck
   task automatic rail_update();
      logic pen;
      pen = !(ph == M_OFFW || ph == M_OFF);
      if (!stuck && pwr_good_i != pen) begin
         if (rail_cnt == 0) pwr_good_i = pen;
         else rail_cnt--;
      end else begin
         rail_cnt = rail_dly;
      end
   endtask

   task automatic tick(input logic r, input logic dn, input logic up, input logic [W-1:0] d);
      @(negedge clk);
      rail_update();
      rst_i = r;
      pwr_down_req_i = dn;
      pwr_up_req_i = up;
      data_i = d;
      model_step();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 1'b0, $urandom);
   endtask

   initial begin : monitor
      logic [W+5:0] e, a;
      forever begin
         @(posedge clk);
         #1;
         if (expq.size() > 0) begin
            e = expq.pop_front();
            a = {data_o, iso_o, pwr_en_o, busy_o, err_o, pwr_down_ack_o, pwr_up_ack_o};
            checks++;
            if (a !== e) begin
               errors++;
               $display("FAIL outputs t=%0t got data=%h iso/en/busy/err/dack/uack=%b want data=%h iso/en/busy/err/dack/uack=%b",
                        $time, a[W+5:6], a[5:0], e[W+5:6], e[5:0]);
            end
         end
      end
   end

   initial begin : driver
      tick(1'b1, 1'b0, 1'b0, $urandom);
      tick(1'b1, 1'b0, 1'b0, $urandom);
      idle(12);
      // pattern pass-through, then a single power-down pulse
      tick(1'b0, 1'b0, 1'b0, 32'hA5A5_0F0F);
      tick(1'b0, 1'b1, 1'b0, 32'h1234_5678);
      idle(16);
      // both requests in OFF, then up held well past its ack
      tick(1'b0, 1'b1, 1'b1, $urandom);
      for (int i = 0; i < 20; i++) tick(1'b0, 1'b0, 1'b1, $urandom);
      // down request toggled during power-down/up, then held into ACTIVE
      tick(1'b0, 1'b1, 1'b0, $urandom);
      idle(14);
      tick(1'b0, 1'b0, 1'b1, $urandom);
      for (int i = 0; i < 20; i++) tick(1'b0, 1'(i % 2), 1'b0, $urandom);
      for (int i = 0; i < 12; i++) tick(1'b0, 1'b1, 1'b0, $urandom);
      idle(6);
      tick(1'b0, 1'b0, 1'b1, $urandom);
      idle(20);
      // rail stuck high: power-off timeout, err must survive a full cycle
      stuck = 1'b1;
      tick(1'b0, 1'b1, 1'b0, $urandom);
      idle(26);
      stuck = 1'b0;
      tick(1'b0, 1'b0, 1'b1, $urandom);
      idle(15);
      tick(1'b0, 1'b1, 1'b0, $urandom);
      idle(15);
      tick(1'b0, 1'b0, 1'b1, $urandom);
      idle(20);
      // reset while waiting for the rail to drop
      stuck = 1'b1;
      tick(1'b0, 1'b1, 1'b0, $urandom);
      idle(SETUP + 2);
      tick(1'b1, 1'b0, 1'b0, $urandom);
      stuck = 1'b0;
      idle(20);
      // randomized traffic
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 199) == 0) stuck = ~stuck;
         if ($urandom_range(0, 49) == 0) rail_dly = $urandom_range(0, 5);
         tick(1'($urandom_range(0, 499) == 0), 1'($urandom_range(0, 7) == 0),
              1'($urandom_range(0, 7) == 0), $urandom);
      end
      @(posedge clk);
      #2;
      checks++;
      if (expq.size() != 0) begin
         errors++;
         $display("FAIL drain got %0d pending want 0", expq.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
